vga_timing: RTL and testbench

Pixel-timing generator for the 640x480@60 VGA display path. It divides the system clock down to the pixel rate and scans a raster counter over active video and blanking. It drives the `x`/`y`/`vsync` inputs consumed by the ball and paddle controllers, and the negative-polarity sync pins for the connector. It also produces blanking, frame-start and frame-count outputs so that downstream colour muxing and game logic share one raster reference.

---
 rtl/vga_timing.sv | 124 ++++++++++++
 tb/tb_vga_timing.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// Pixel-rate raster generator for a VGA display path: divides clk to the pixel
// rate, scans x/y over active video and blanking, and produces sync/blank/frame markers.
module vga_timing #(
    parameter int unsigned CLKDIV   = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixstb,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       vga_hs_n,
    output logic       vga_vs_n,
    output logic       frame_start,
    output logic [7:0] frame
);

    localparam int unsigned CW      = 10;
    localparam int unsigned EW      = 11;
    localparam int unsigned FW      = 8;
    localparam int unsigned DIV_W   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [CW-1:0]    X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    Y_LAST   = CW'(V_TOTAL - 1);

    // Decode bounds are one bit wider so a sync ending exactly at 1024 still compares correctly.
    localparam logic [EW-1:0] H_ACT_E = EW'(H_ACTIVE);
    localparam logic [EW-1:0] H_SS_E  = EW'(H_ACTIVE + H_FP);
    localparam logic [EW-1:0] H_SE_E  = EW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [EW-1:0] V_ACT_E = EW'(V_ACTIVE);
    localparam logic [EW-1:0] V_SS_E  = EW'(V_ACTIVE + V_FP);
    localparam logic [EW-1:0] V_SE_E  = EW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] divcnt;

    logic          adv_c;
    logic          x_wrap_c;
    logic          y_wrap_c;
    logic [CW-1:0] x_nxt_c;
    logic [CW-1:0] y_nxt_c;
    logic [EW-1:0] x_ext_c;
    logic [EW-1:0] y_ext_c;
    logic          active_nxt_c;
    logic          hsync_nxt_c;
    logic          vsync_nxt_c;

    // Next raster position and the decodes that describe it.
    always_comb begin
        adv_c        = 1'b0;
        x_wrap_c     = 1'b0;
        y_wrap_c     = 1'b0;
        x_nxt_c      = x;
        y_nxt_c      = y;
        x_ext_c      = '0;
        y_ext_c      = '0;
        active_nxt_c = 1'b0;
        hsync_nxt_c  = 1'b0;
        vsync_nxt_c  = 1'b0;

        adv_c    = (divcnt == DIV_LAST);
        x_wrap_c = (x == X_LAST);
        y_wrap_c = (y == Y_LAST);

        if (x_wrap_c) begin
            x_nxt_c = '0;
            y_nxt_c = y_wrap_c ? '0 : y + CW'(1);
        end else begin
            x_nxt_c = x + CW'(1);
        end

        x_ext_c      = {1'b0, x_nxt_c};
        y_ext_c      = {1'b0, y_nxt_c};
        active_nxt_c = (x_ext_c < H_ACT_E) && (y_ext_c < V_ACT_E);
        hsync_nxt_c  = (x_ext_c >= H_SS_E) && (x_ext_c < H_SE_E);
        vsync_nxt_c  = (y_ext_c >= V_SS_E) && (y_ext_c < V_SE_E);
    end

    // Divider, raster and all registered outputs; decodes only move on the pixel edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divcnt      <= '0;
            x           <= '0;
            y           <= '0;
            active      <= 1'b1;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            vga_hs_n    <= 1'b1;
            vga_vs_n    <= 1'b1;
            pixstb      <= 1'b0;
            frame_start <= 1'b0;
            frame       <= '0;
        end else begin
            divcnt      <= adv_c ? '0 : divcnt + DIV_W'(1);
            pixstb      <= adv_c;
            frame_start <= adv_c && x_wrap_c && y_wrap_c;
            if (adv_c) begin
                x        <= x_nxt_c;
                y        <= y_nxt_c;
                active   <= active_nxt_c;
                hsync    <= hsync_nxt_c;
                vsync    <= vsync_nxt_c;
                vga_hs_n <= ~hsync_nxt_c;
                vga_vs_n <= ~vsync_nxt_c;
                if (x_wrap_c && y_wrap_c) begin
                    frame <= frame + FW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three raster geometries checked cycle by cycle against a
// closed-form model that derives every output from the number of clocks since reset.
module tb_vga_timing;

    localparam int A_CD = 2, A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
    localparam int A_VA = 480, A_VFP = 10, A_VS = 2, A_VBP = 33;
    localparam int B_CD = 3, B_HA = 16, B_HFP = 2, B_HS = 3, B_HBP = 3;
    localparam int B_VA = 8, B_VFP = 2, B_VS = 2, B_VBP = 3;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;
    localparam int B_FRAME = B_HT * B_VT * B_CD;
    localparam int C_CD = 1, C_HA = 4, C_HFP = 1, C_HS = 2, C_HBP = 1;
    localparam int C_VA = 1, C_VFP = 1, C_VS = 1, C_VBP = 1;
    localparam int C_FRAME = (C_HA + C_HFP + C_HS + C_HBP) * (C_VA + C_VFP + C_VS + C_VBP) * C_CD;

    // {x, y, frame, pixstb, frame_start, active, hsync, vsync, vga_hs_n, vga_vs_n}
    localparam logic [34:0] RST_V = {10'd0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int total = 0;
    int bad = 0;

    logic       a_pixstb, a_active, a_hsync, a_vsync, a_hs_n, a_vs_n, a_fs;
    logic [9:0] a_x, a_y;
    logic [7:0] a_frame;
    logic       b_pixstb, b_active, b_hsync, b_vsync, b_hs_n, b_vs_n, b_fs;
    logic [9:0] b_x, b_y;
    logic [7:0] b_frame;
    logic       c_pixstb, c_active, c_hsync, c_vsync, c_hs_n, c_vs_n, c_fs;
    logic [9:0] c_x, c_y;
    logic [7:0] c_frame;

    vga_timing dut_a (
        .clk(clk), .rst(rst_a), .pixstb(a_pixstb), .x(a_x), .y(a_y), .active(a_active),
        .hsync(a_hsync), .vsync(a_vsync), .vga_hs_n(a_hs_n), .vga_vs_n(a_vs_n),
        .frame_start(a_fs), .frame(a_frame)
    );

    vga_timing #(
        .CLKDIV(B_CD), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pixstb(b_pixstb), .x(b_x), .y(b_y), .active(b_active),
        .hsync(b_hsync), .vsync(b_vsync), .vga_hs_n(b_hs_n), .vga_vs_n(b_vs_n),
        .frame_start(b_fs), .frame(b_frame)
    );

    vga_timing #(
        .CLKDIV(C_CD), .H_ACTIVE(C_HA), .H_FP(C_HFP), .H_SYNC(C_HS), .H_BP(C_HBP),
        .V_ACTIVE(C_VA), .V_FP(C_VFP), .V_SYNC(C_VS), .V_BP(C_VBP)
    ) dut_c (
        .clk(clk), .rst(rst_c), .pixstb(c_pixstb), .x(c_x), .y(c_y), .active(c_active),
        .hsync(c_hsync), .vsync(c_vsync), .vga_hs_n(c_hs_n), .vga_vs_n(c_vs_n),
        .frame_start(c_fs), .frame(c_frame)
    );

    logic [34:0] a_obs, b_obs, c_obs;
    assign a_obs = {a_x, a_y, a_frame, a_pixstb, a_fs, a_active, a_hsync, a_vsync, a_hs_n, a_vs_n};
    assign b_obs = {b_x, b_y, b_frame, b_pixstb, b_fs, b_active, b_hsync, b_vsync, b_hs_n, b_vs_n};
    assign c_obs = {c_x, c_y, c_frame, c_pixstb, c_fs, c_active, c_hsync, c_vsync, c_hs_n, c_vs_n};

    // Expected outputs after n clock edges since reset release: pixel index p = n / cd.
    function automatic logic [34:0] model(longint n, int cd, int ha, int hfp, int hs, int hbp,
                                          int va, int vfp, int vs, int vbp);
        longint ht, vt, p, px, py, fr;
        logic ps, fs, act, h, v;
        ht  = longint'(ha + hfp + hs + hbp);
        vt  = longint'(va + vfp + vs + vbp);
        p   = n / longint'(cd);
        px  = p % ht;
        py  = (p / ht) % vt;
        fr  = (p / (ht * vt)) % 256;
        ps  = (n > 0) && ((n % longint'(cd)) == 0);
        fs  = ps && ((p % (ht * vt)) == 0);
        act = (px < ha) && (py < va);
        h   = (px >= ha + hfp) && (px < ha + hfp + hs);
        v   = (py >= va + vfp) && (py < va + vfp + vs);
        return {10'(px), 10'(py), 8'(fr), ps, fs, act, h, v, ~h, ~v};
    endfunction

    function automatic logic [34:0] model_a(longint n);
        return model(n, A_CD, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP);
    endfunction

    function automatic logic [34:0] model_b(longint n);
        return model(n, B_CD, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP);
    endfunction

    function automatic logic [34:0] model_c(longint n);
        return model(n, C_CD, C_HA, C_HFP, C_HS, C_HBP, C_VA, C_VFP, C_VS, C_VBP);
    endfunction

    task automatic test_reset;
        int hold;
        hold = int'($urandom_range(2, 6));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            total++;
            if (a_obs !== RST_V) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, a_obs, RST_V);
            end
        end
        @(negedge clk); rst_a = 1'b1;
        #1;
        total++;
        if (a_obs !== model_a(0)) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", a_obs, model_a(0));
        end
        for (longint n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            total++;
            if (a_obs !== model_a(n)) begin
                bad++;
                $display("FAIL reset_first_pixels n=%0d got=%h want=%h", n, a_obs, model_a(n));
            end
            if (n == 2) begin
                total++;
                if ({a_pixstb, a_x, a_y} !== {1'b1, 10'd1, 10'd0}) begin
                    bad++;
                    $display("FAIL first_pixstb got ps=%0b x=%0d y=%0d want ps=1 x=1 y=0",
                             a_pixstb, a_x, a_y);
                end
            end
        end
    endtask

    task automatic test_hsync;
        longint rise_n = -1, fall_n = -1;
        int rise_x = -1, fall_x = -1;
        logic prev = 1'b0;
        @(negedge clk); rst_a = 1'b0;
        @(negedge clk); rst_a = 1'b1;
        for (longint n = 1; n <= 1700; n++) begin
            @(posedge clk); #1;
            total++;
            if (a_obs !== model_a(n)) begin
                bad++;
                $display("FAIL hsync_scan n=%0d got=%h want=%h", n, a_obs, model_a(n));
            end
            if (a_hsync && !prev && rise_n < 0) begin rise_n = n; rise_x = int'(a_x); end
            if (!a_hsync && prev && fall_n < 0) begin fall_n = n; fall_x = int'(a_x); end
            prev = a_hsync;
        end
        total++;
        if (rise_x != A_HA + A_HFP || fall_x != A_HA + A_HFP + A_HS) begin
            bad++;
            $display("FAIL hsync_edges got rise_x=%0d fall_x=%0d want %0d %0d",
                     rise_x, fall_x, A_HA + A_HFP, A_HA + A_HFP + A_HS);
        end
        total++;
        if (fall_n - rise_n != longint'(A_HS * A_CD)) begin
            bad++;
            $display("FAIL hsync_width got=%0d want=%0d", fall_n - rise_n, A_HS * A_CD);
        end
    endtask

    task automatic test_line_wrap;
        int cnt_last = 0;
        logic ps_first = 1'b0, ps_second = 1'b1, seen_y1 = 1'b0, y1_act = 1'b0;
        int y1_x = -1;
        @(negedge clk); rst_a = 1'b0;
        @(negedge clk); rst_a = 1'b1;
        for (longint n = 1; n <= 1604; n++) begin
            @(posedge clk); #1;
            total++;
            if (a_obs !== model_a(n)) begin
                bad++;
                $display("FAIL line_scan n=%0d got=%h want=%h", n, a_obs, model_a(n));
            end
            if (a_x == 10'd799 && a_y == 10'd0) begin
                if (cnt_last == 0) ps_first = a_pixstb; else ps_second = a_pixstb;
                cnt_last++;
            end
            if (a_y == 10'd1 && !seen_y1) begin
                seen_y1 = 1'b1; y1_x = int'(a_x); y1_act = a_active;
            end
        end
        total++;
        if (cnt_last != A_CD || ps_first !== 1'b1 || ps_second !== 1'b0) begin
            bad++;
            $display("FAIL last_pixel_hold got cycles=%0d ps=%0b%0b want cycles=2 ps=10",
                     cnt_last, ps_first, ps_second);
        end
        total++;
        if (!seen_y1 || y1_x != 0 || y1_act !== 1'b1) begin
            bad++;
            $display("FAIL line_wrap got seen=%0b x=%0d active=%0b want seen=1 x=0 active=1",
                     seen_y1, y1_x, y1_act);
        end
    endtask

    task automatic test_vsync_frame;
        longint rise_n = -1, fall_n = -1, fs1 = -1, fs2 = -1;
        int rise_x = -1, rise_y = -1, fs_run = 0, fs_max = 0, fr1 = -1;
        logic pv = 1'b0;
        @(negedge clk); rst_b = 1'b0;
        @(negedge clk); rst_b = 1'b1;
        for (longint n = 1; n <= 2 * B_FRAME + 20; n++) begin
            @(posedge clk); #1;
            total++;
            if (b_obs !== model_b(n)) begin
                bad++;
                $display("FAIL vsync_scan n=%0d got=%h want=%h", n, b_obs, model_b(n));
            end
            if (b_vsync && !pv && rise_n < 0) begin
                rise_n = n; rise_x = int'(b_x); rise_y = int'(b_y);
            end
            if (!b_vsync && pv && fall_n < 0) fall_n = n;
            pv = b_vsync;
            if (b_fs) begin
                fs_run++;
                if (fs_run == 1) begin
                    if (fs1 < 0) begin fs1 = n; fr1 = int'(b_frame); end
                    else if (fs2 < 0) fs2 = n;
                end
            end else begin
                fs_run = 0;
            end
            if (fs_run > fs_max) fs_max = fs_run;
        end
        total++;
        if (rise_x != 0 || rise_y != B_VA + B_VFP ||
            rise_n != longint'((B_VA + B_VFP) * B_HT * B_CD)) begin
            bad++;
            $display("FAIL vsync_rise got n=%0d x=%0d y=%0d want n=%0d x=0 y=%0d",
                     rise_n, rise_x, rise_y, (B_VA + B_VFP) * B_HT * B_CD, B_VA + B_VFP);
        end
        total++;
        if (fall_n - rise_n != longint'(B_VS * B_HT * B_CD)) begin
            bad++;
            $display("FAIL vsync_width got=%0d want=%0d", fall_n - rise_n, B_VS * B_HT * B_CD);
        end
        total++;
        if (fs1 != longint'(B_FRAME) || fr1 != 1) begin
            bad++;
            $display("FAIL first_frame_start got n=%0d frame=%0d want n=%0d frame=1",
                     fs1, fr1, B_FRAME);
        end
        total++;
        if (fs2 - fs1 != longint'(B_FRAME) || fs_max != 1) begin
            bad++;
            $display("FAIL frame_period got=%0d width=%0d want=%0d width=1",
                     fs2 - fs1, fs_max, B_FRAME);
        end
    endtask

    task automatic test_frame_wrap;
        int pulses = 0, fs_run = 0, fs_max = 0, no_stb = 0;
        int wrap_prev = -1, wrap_now = -1, prev_frame = 0;
        @(negedge clk); rst_c = 1'b0;
        @(negedge clk); rst_c = 1'b1;
        for (longint n = 1; n <= 256 * C_FRAME + 8; n++) begin
            @(posedge clk); #1;
            total++;
            if (c_obs !== model_c(n)) begin
                bad++;
                $display("FAIL frame_wrap_scan n=%0d got=%h want=%h", n, c_obs, model_c(n));
            end
            if (!c_pixstb) no_stb++;
            if (c_fs) begin
                fs_run++;
                pulses++;
                if (pulses == 256) begin wrap_prev = prev_frame; wrap_now = int'(c_frame); end
            end else begin
                fs_run = 0;
            end
            if (fs_run > fs_max) fs_max = fs_run;
            prev_frame = int'(c_frame);
        end
        total++;
        if (pulses != 256 || wrap_prev != 255 || wrap_now != 0) begin
            bad++;
            $display("FAIL frame_counter_wrap got pulses=%0d %0d->%0d want 256 255->0",
                     pulses, wrap_prev, wrap_now);
        end
        total++;
        if (fs_max != 1 || no_stb != 0) begin
            bad++;
            $display("FAIL div1_strobes got fs_width=%0d stb_low=%0d want 1 0", fs_max, no_stb);
        end
    endtask

    task automatic test_reset_midframe;
        longint target;
        int ty;
        for (int it = 0; it < 6; it++) begin
            @(negedge clk); rst_b = 1'b0;
            @(negedge clk); rst_b = 1'b1;
            if (it == 0) begin
                ty = int'($urandom_range(1, B_VT - 2));
                target = longint'((ty * B_HT + B_HA + B_HFP + 1) * B_CD) +
                         longint'($urandom_range(0, B_CD - 1));
            end else begin
                target = longint'($urandom_range(1, 3 * B_FRAME));
            end
            for (longint n = 1; n <= target; n++) begin
                @(posedge clk); #1;
                total++;
                if (b_obs !== model_b(n)) begin
                    bad++;
                    $display("FAIL midframe_run it=%0d n=%0d got=%h want=%h",
                             it, n, b_obs, model_b(n));
                end
            end
            if (it == 0) begin
                total++;
                if (b_hsync !== 1'b1 || b_y != 10'(ty)) begin
                    bad++;
                    $display("FAIL midframe_in_hsync got hs=%0b y=%0d want hs=1 y=%0d",
                             b_hsync, b_y, ty);
                end
            end
            #($urandom_range(1, 7));
            rst_b = 1'b0;
            #1;
            total++;
            if (b_obs !== RST_V) begin
                bad++;
                $display("FAIL async_reset it=%0d got=%h want=%h", it, b_obs, RST_V);
            end
            repeat (2) @(posedge clk);
            @(negedge clk); rst_b = 1'b1;
            for (longint n = 1; n <= 40; n++) begin
                @(posedge clk); #1;
                total++;
                if (b_obs !== model_b(n)) begin
                    bad++;
                    $display("FAIL restart it=%0d n=%0d got=%h want=%h", it, n, b_obs, model_b(n));
                end
            end
        end
    endtask

    initial begin
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        test_reset();
        test_hsync();
        test_line_wrap();
        test_vsync_frame();
        test_frame_wrap();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
